// File: rtl/demux_n_stream_pkg.sv
// Shared types and constants for the 1-to-N stream demultiplexer.
package demux_n_stream_pkg;

  localparam int unsigned DropCntWidth = 16;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/demux_n_stream_hold_reg.sv
// Single-beat output holding register with per-channel ready selection.
module demux_n_stream_hold_reg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [SEL_WIDTH-1:0]  ch_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic [N_CH-1:0]       m_ready_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [SEL_WIDTH-1:0]  ch_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q, valid_d;
  logic [SEL_WIDTH-1:0]  ch_q, ch_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  sel_ready;
  logic                  drain;

  // Ready of the channel currently holding the beat; no path from s_valid_i.
  always_comb begin
    sel_ready = 1'b0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (ch_q == SEL_WIDTH'(k)) sel_ready = m_ready_i[k];
    end
  end

  assign drain   = valid_q & sel_ready;
  assign ready_o = ~valid_q | sel_ready;

  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      ch_d    = ch_i;
      data_d  = data_i;
      last_d  = last_i;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign ch_o    = ch_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/demux_n_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with optional packet-level channel lock.
module demux_n_stream
  import demux_n_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter bit          PACKET_MODE = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [DATA_WIDTH-1:0]      s_data_i,
  input  logic                       s_last_i,
  input  logic [SEL_WIDTH-1:0]       select_i,
  output logic [N_CH-1:0]            m_valid_o,
  input  logic [N_CH-1:0]            m_ready_i,
  output logic [N_CH*DATA_WIDTH-1:0] m_data_o,
  output logic [N_CH-1:0]            m_last_o,
  output logic                       err_o,
  output logic [DropCntWidth-1:0]    drop_cnt_o
);

  if (N_CH < 2 || N_CH > 16 || SEL_WIDTH < clog2(N_CH)) begin : g_bad_params
    $error("demux_n_stream: illegal N_CH/SEL_WIDTH combination");
  end

  state_e                   state_q, state_d;
  logic [SEL_WIDTH-1:0]     lock_sel_q, lock_sel_d;
  logic                     err_q, err_d;
  logic [DropCntWidth-1:0]  drop_cnt_q, drop_cnt_d;
  logic [SEL_WIDTH-1:0]     eff_sel;
  logic                     in_range, accept, load, drop;
  logic                     hold_ready, hold_v, hold_last;
  logic [SEL_WIDTH-1:0]     hold_ch;
  logic [DATA_WIDTH-1:0]    hold_data;

  always_comb begin
    eff_sel = select_i;
    if (PACKET_MODE && state_q == StLocked) eff_sel = lock_sel_q;
  end

  assign in_range  = 32'(eff_sel) < N_CH;
  assign accept    = s_valid_i & hold_ready;
  assign load      = accept & in_range;
  // Out-of-range beats are still accepted so the producer never stalls on them.
  assign drop      = accept & ~in_range;
  assign s_ready_o = hold_ready;

  demux_n_stream_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_CH       (N_CH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_hold_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .ch_i      (eff_sel),
    .data_i    (s_data_i),
    .last_i    (s_last_i),
    .m_ready_i (m_ready_i),
    .ready_o   (hold_ready),
    .valid_o   (hold_v),
    .ch_o      (hold_ch),
    .data_o    (hold_data),
    .last_o    (hold_last)
  );

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (PACKET_MODE && accept) begin
      unique case (state_q)
        StIdle: begin
          if (!s_last_i) begin
            state_d    = StLocked;
            lock_sel_d = select_i;
          end
        end
        StLocked: begin
          if (s_last_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    err_d      = drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    m_valid_o = '0;
    m_data_o  = '0;
    m_last_o  = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (hold_v && hold_ch == SEL_WIDTH'(k)) begin
        m_valid_o[k]                       = 1'b1;
        m_data_o[k*DATA_WIDTH +: DATA_WIDTH] = hold_data;
        m_last_o[k]                        = hold_last;
      end
    end
  end

  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_demux_n_stream.sv
// Directed bench: per-beat mode, packet mode, and a 3-channel instance for range errors.
module tb_demux_n_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, v2;
  logic [7:0]  s_data;
  logic        s_last;
  logic [1:0]  sel;
  logic [3:0]  m_ready;

  logic        s_ready0, s_ready1, s_ready2;
  logic [3:0]  m_valid0, m_valid1, m_last0, m_last1;
  logic [2:0]  m_valid2, m_last2;
  logic [31:0] m_data0, m_data1;
  logic [23:0] m_data2;
  logic        err0, err1, err2;
  logic [15:0] drop0, drop1, drop2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux_n_stream #(.DATA_WIDTH(8), .N_CH(4), .SEL_WIDTH(2), .PACKET_MODE(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(v0), .s_ready_o(s_ready0), .s_data_i(s_data),
    .s_last_i(s_last), .select_i(sel), .m_valid_o(m_valid0), .m_ready_i(m_ready),
    .m_data_o(m_data0), .m_last_o(m_last0), .err_o(err0), .drop_cnt_o(drop0)
  );

  demux_n_stream #(.DATA_WIDTH(8), .N_CH(4), .SEL_WIDTH(2), .PACKET_MODE(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(v1), .s_ready_o(s_ready1), .s_data_i(s_data),
    .s_last_i(s_last), .select_i(sel), .m_valid_o(m_valid1), .m_ready_i(m_ready),
    .m_data_o(m_data1), .m_last_o(m_last1), .err_o(err1), .drop_cnt_o(drop1)
  );

  demux_n_stream #(.DATA_WIDTH(8), .N_CH(3), .SEL_WIDTH(2), .PACKET_MODE(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .s_valid_i(v2), .s_ready_o(s_ready2), .s_data_i(s_data),
    .s_last_i(s_last), .select_i(sel), .m_valid_o(m_valid2), .m_ready_i(m_ready[2:0]),
    .m_data_o(m_data2), .m_last_o(m_last2), .err_o(err2), .drop_cnt_o(drop2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic l);
    s_data = d;
    sel    = s;
    s_last = l;
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
    drive(8'hEE, 2'd0, 1'b1);
    m_ready = 4'b1111;

    // 1: reset with valid asserted
    repeat (3) tick();
    check("rst_valid0", 32'(m_valid0), 32'h0);
    check("rst_valid1", 32'(m_valid1), 32'h0);
    check("rst_data0", m_data0, 32'h0);
    check("rst_drop2", 32'(drop2), 32'h0);
    check("rst_err2", 32'(err2), 32'h0);
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    tick();
    check("idle_valid0", 32'(m_valid0), 32'h0);

    // 2: per-beat routing at full rate
    v0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'hA0 + 8'(i), 2'(i), 1'b0);
      check("p0_sready", 32'(s_ready0), 32'h1);
      tick();
      check("p0_valid", 32'(m_valid0), 32'h1 << i);
      check("p0_data", 32'(m_data0[i*8 +: 8]), 32'hA0 + 32'(i));
    end
    v0 = 1'b0;
    tick();
    check("p0_drained", 32'(m_valid0), 32'h0);

    // 3: backpressure on ch2, then release with back-to-back reload
    m_ready = 4'b1011;
    v0 = 1'b1;
    drive(8'h55, 2'd2, 1'b0);
    tick();
    drive(8'h66, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_sready", 32'(s_ready0), 32'h0);
      check("bp_valid", 32'(m_valid0), 32'b0100);
      check("bp_data", 32'(m_data0[16 +: 8]), 32'h55);
      tick();
    end
    m_ready = 4'b1111;
    #1;
    check("bp_release_sready", 32'(s_ready0), 32'h1);
    tick();
    check("bp_next_valid", 32'(m_valid0), 32'b0100);
    check("bp_next_data", 32'(m_data0[16 +: 8]), 32'h66);
    v0 = 1'b0;
    tick();
    check("bp_done", 32'(m_valid0), 32'h0);

    // 4: packet lock holds ch1 despite select changes
    v1 = 1'b1;
    drive(8'h10, 2'd1, 1'b0);
    tick();
    check("pk_b0_valid", 32'(m_valid1), 32'b0010);
    check("pk_b0_last", 32'(m_last1), 32'h0);
    drive(8'h11, 2'd3, 1'b0);
    tick();
    check("pk_b1_valid", 32'(m_valid1), 32'b0010);
    check("pk_b1_data", 32'(m_data1[8 +: 8]), 32'h11);
    drive(8'h12, 2'd3, 1'b1);
    tick();
    check("pk_b2_valid", 32'(m_valid1), 32'b0010);
    check("pk_b2_last", 32'(m_last1), 32'b0010);
    check("pk_b2_data", 32'(m_data1[8 +: 8]), 32'h12);
    drive(8'h20, 2'd3, 1'b1);
    tick();
    check("pk_next_valid", 32'(m_valid1), 32'b1000);
    check("pk_next_data", 32'(m_data1[24 +: 8]), 32'h20);
    v1 = 1'b0;
    tick();

    // 5: out-of-range select on a 3-channel instance
    v2 = 1'b1;
    drive(8'h77, 2'd3, 1'b1);
    tick();
    check("oor_valid", 32'(m_valid2), 32'h0);
    check("oor_err", 32'(err2), 32'h1);
    check("oor_drop", 32'(drop2), 32'h1);
    v2 = 1'b0;
    tick();
    check("oor_err_pulse", 32'(err2), 32'h0);
    v2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'h30 + 8'(i), (i == 0) ? 2'd3 : 2'd0, (i == 3));
      check("oor_pk_sready", 32'(s_ready2), 32'h1);
      tick();
      check("oor_pk_valid", 32'(m_valid2), 32'h0);
    end
    check("oor_pk_drop", 32'(drop2), 32'h5);
    drive(8'h88, 2'd1, 1'b1);
    tick();
    check("oor_idle_valid", 32'(m_valid2), 32'b010);
    check("oor_idle_data", 32'(m_data2[8 +: 8]), 32'h88);
    v2 = 1'b0;
    tick();

    // 6: reset mid-packet drops the lock and the held beat
    v1 = 1'b1;
    drive(8'h40, 2'd1, 1'b0);
    tick();
    v1 = 1'b0;
    m_ready = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = 4'b1111;
    #1;
    check("mid_rst_valid", 32'(m_valid1), 32'h0);
    v1 = 1'b1;
    drive(8'h42, 2'd2, 1'b1);
    tick();
    check("mid_rst_route", 32'(m_valid1), 32'b0100);
    check("mid_rst_data", 32'(m_data1[16 +: 8]), 32'h42);
    v1 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
